// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded instruction for EX, detects
// load-use hazards against the instruction already in EX and inserts bubbles.
module id_ex_stage_reg #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_extdimm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_uses_rt,
    input  logic [9:0]    id_ctrl,
    input  logic          flush,
    input  logic          hold,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_extdimm,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic [9:0]    ex_ctrl,
    output logic          ex_valid,
    output logic          stall_out,
    output logic [CW-1:0] bubble_cnt
);

    localparam int MEMREAD_BIT = 6;

    logic [DW-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [9:0]    ctrl_q, ctrl_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_use;

    // $0 is hard-wired, so a load targeting it can never create a dependency
    assign load_use = valid_q & ctrl_q[MEMREAD_BIT] & (rt_q != '0) &
                      ((rt_q == id_rs) | (id_uses_rt & (rt_q == id_rt)));
    assign stall_out = load_use & ~hold;

    always_comb begin
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (stall_out) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        end else begin
            pc4_d   = id_pc4;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_extdimm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            ctrl_d  = id_ctrl;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_pc4     = pc4_q;
    assign ex_rd1     = rd1_q;
    assign ex_rd2     = rd2_q;
    assign ex_extdimm = imm_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_valid   = valid_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver predicts each edge with a
// behavioural model and queues it, monitor compares after every rising edge.
module tb_id_ex_stage_reg;

    localparam logic [9:0] LW_CTRL  = 10'b1101010010;
    localparam logic [9:0] ADD_CTRL = 10'b1000001010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_pc4 = '0, id_rd1 = '0, id_rd2 = '0, id_extdimm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_uses_rt = 1'b0;
    logic [9:0]  id_ctrl = '0;
    logic        flush = 1'b0, hold = 1'b0;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_extdimm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [9:0]  ex_ctrl;
    logic        ex_valid, stall_out;
    logic [3:0]  bubble_cnt;

    id_ex_stage_reg #(.DW(32), .RW(5), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_extdimm(id_extdimm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_extdimm(ex_extdimm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_valid(ex_valid), .stall_out(stall_out), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [9:0]  ctrl;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   n_tests = 0;
    int   n_fail = 0;
    logic stall_pre;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t zero_state();
        exp_t z;
        z.stall = 1'b0; z.valid = 1'b0; z.ctrl = '0;
        z.pc4 = '0; z.rd1 = '0; z.rd2 = '0; z.imm = '0;
        z.rs = '0; z.rt = '0; z.rd = '0; z.cnt = 0;
        return z;
    endfunction

    // Model of one edge: inputs are already applied; predicts stall before the
    // edge and the EX contents after it, then waits for the next falling edge.
    task automatic step();
        exp_t e;
        logic hazard;
        if (!rst_n) m = zero_state();
        hazard = m.valid && m.ctrl[6] && (m.rt != 0) &&
                 ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
        e.stall = hazard && !hold;
        if (!rst_n) begin
            m = zero_state();
        end else if (flush) begin
            m.valid = 1'b0;
            m.ctrl  = '0;
        end else if (hold) begin
            m = m;
        end else if (e.stall) begin
            m.valid = 1'b0;
            m.ctrl  = '0;
            m.cnt   = (m.cnt >= 15) ? 15 : m.cnt + 1;
        end else begin
            m.valid = 1'b1;
            m.ctrl = id_ctrl;
            m.pc4 = id_pc4; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_extdimm;
            m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
        end
        e.valid = m.valid; e.ctrl = m.ctrl; e.cnt = m.cnt;
        e.pc4 = m.pc4; e.rd1 = m.rd1; e.rd2 = m.rd2; e.imm = m.imm;
        e.rs = m.rs; e.rt = m.rt; e.rd = m.rd;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_id(input logic [9:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses_rt, input logic fl, input logic hd);
        id_ctrl = ctrl; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
        id_rd = 5'($urandom); flush = fl; hold = hd;
        id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_extdimm = $urandom;
    endtask

    task automatic randomize_id();
        set_id(10'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    endtask

    always @(posedge clk) stall_pre <= stall_out;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stall_out", {31'b0, stall_pre}, {31'b0, e.stall});
                check("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
                check("ex_ctrl", {22'b0, ex_ctrl}, {22'b0, e.ctrl});
                check("bubble_cnt", {28'b0, bubble_cnt}, 32'(e.cnt));
                if (e.valid) begin
                    check("ex_pc4", ex_pc4, e.pc4);
                    check("ex_rd1", ex_rd1, e.rd1);
                    check("ex_rd2", ex_rd2, e.rd2);
                    check("ex_extdimm", ex_extdimm, e.imm);
                    check("ex_specs", {17'b0, ex_rs, ex_rt, ex_rd}, {17'b0, e.rs, e.rt, e.rd});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        m = zero_state();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            step();
        end
        check("reset_valid", {31'b0, ex_valid}, 32'd0);
        check("reset_data", ex_extdimm | ex_rd1 | ex_pc4 | ex_rd2, 32'd0);
        rst_n = 1'b1;

        set_id(10'b1000010010, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        id_extdimm = 32'hFFFF_FFFD;
        id_rd1 = 32'h0000_0010;
        step();

        set_id(LW_CTRL, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        set_id(ADD_CTRL, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        step();

        set_id(LW_CTRL, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_id(ADD_CTRL, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        set_id(LW_CTRL, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        set_id(LW_CTRL, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
        step();

        set_id(LW_CTRL, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        set_id(ADD_CTRL, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        step();
        set_id(LW_CTRL, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_id(ADD_CTRL, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
            step();
        end
        set_id(ADD_CTRL, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        step();

        for (int i = 0; i < 400; i++) begin
            randomize_id();
            step();
        end

        set_id(ADD_CTRL, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, ex_valid}, 32'd0);
        check("async_reset_ctrl", {22'b0, ex_ctrl}, 32'd0);
        check("async_reset_data", ex_rd1 | ex_pc4, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            step();
        end
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            set_id(LW_CTRL, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
            step();
        end
        check("saturated_cnt", {28'b0, bubble_cnt}, 32'h0000_000F);

        flush = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
